// File: rtl/wir_param.sv
// wir_param: IEEE 1500 wrapper instruction register with opcode/length check and WBY/WBR control decode
module wir_param #(
  parameter int IR_WIDTH = 4,
  parameter logic [IR_WIDTH-1:0] OPC_BYPASS  = IR_WIDTH'(0),
  parameter logic [IR_WIDTH-1:0] OPC_EXTEST  = IR_WIDTH'(1),
  parameter logic [IR_WIDTH-1:0] OPC_INTEST  = IR_WIDTH'(2),
  parameter logic [IR_WIDTH-1:0] OPC_PRELOAD = IR_WIDTH'(3),
  parameter logic [IR_WIDTH-1:0] OPC_SAFE    = IR_WIDTH'(4)
) (
  input  logic                WRCK,
  input  logic                WRST,
  input  logic                SelectWIR,
  input  logic                ShiftWR,
  input  logic                CaptureWR,
  input  logic                UpdateWR,
  input  logic                wsi,
  input  logic                wby_so,
  input  logic                wbr_so,
  output logic                wso,
  output logic [IR_WIDTH-1:0] instr,
  output logic                wby_shift,
  output logic                wby_capture,
  output logic                wbr_shift,
  output logic                wbr_capture,
  output logic                wbr_update,
  output logic                extest,
  output logic                intest,
  output logic                safe,
  output logic                hold_inputs,
  output logic                hold_outputs,
  output logic                bus_disable,
  output logic                illegal_err
);
  localparam int CW = $clog2(IR_WIDTH + 1);
  localparam logic [CW-1:0] CNT_FULL = CW'(IR_WIDTH);
  logic [IR_WIDTH-1:0] sr_q, sr_d, upd_q, upd_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic err_q, err_d;
  logic cap, sh, up, legal;
  logic bypass, preload, wbr_act, wby_act;
  // WIR operation select with capture > shift > update, and update acceptance check
  always_comb begin
    cap   = SelectWIR & CaptureWR;
    sh    = SelectWIR & ~CaptureWR & ShiftWR;
    up    = SelectWIR & ~CaptureWR & ~ShiftWR & UpdateWR;
    legal = (cnt_q == CNT_FULL) &&
            (sr_q inside {OPC_BYPASS, OPC_EXTEST, OPC_INTEST, OPC_PRELOAD, OPC_SAFE});
  end
  // Next-state for shift stage, update stage, length counter and sticky error
  always_comb begin
    sr_d  = cap ? {upd_q[IR_WIDTH-1:2], 2'b01} : sh ? {wsi, sr_q[IR_WIDTH-1:1]} : sr_q;
    cnt_d = (cap | up) ? '0 : (sh && cnt_q != CNT_FULL) ? cnt_q + 1'b1 : cnt_q;
    upd_d = up ? (legal ? sr_q : OPC_BYPASS) : upd_q;
    err_d = err_q | (up & ~legal);
  end
  // State registers; reset overrides any in-flight shift or update
  always_ff @(posedge WRCK) begin
    if (WRST) begin
      sr_q  <= OPC_BYPASS;
      upd_q <= OPC_BYPASS;
      cnt_q <= '0;
      err_q <= 1'b0;
    end else begin
      sr_q  <= sr_d;
      upd_q <= upd_d;
      cnt_q <= cnt_d;
      err_q <= err_d;
    end
  end
  // Instruction decode and data-register control gating
  always_comb begin
    bypass       = upd_q == OPC_BYPASS;
    extest       = upd_q == OPC_EXTEST;
    intest       = upd_q == OPC_INTEST;
    preload      = upd_q == OPC_PRELOAD;
    safe         = upd_q == OPC_SAFE;
    wbr_act      = extest | intest | preload;
    wby_act      = bypass | safe;
    hold_inputs  = safe;
    hold_outputs = safe;
    bus_disable  = safe;
    wby_shift    = ~SelectWIR & ShiftWR & wby_act;
    wby_capture  = ~SelectWIR & CaptureWR & wby_act;
    wbr_shift    = ~SelectWIR & ShiftWR & wbr_act;
    wbr_capture  = ~SelectWIR & CaptureWR & (extest | intest);
    wbr_update   = ~SelectWIR & UpdateWR & wbr_act;
    wso          = SelectWIR ? sr_q[0] : wbr_act ? wbr_so : wby_so;
    instr        = upd_q;
    illegal_err  = err_q;
  end
endmodule

// File: doc/wir_param.md
Name: wir_param

Overview:
- Parametrised IEEE 1500 wrapper instruction register (WIR) with an integrated instruction decoder.
- Shifts, captures and updates an IR_WIDTH-bit instruction and checks the opcode and the shift length before committing it.
- Drives the wrapper boundary register (WBR), wrapper bypass register (WBY) and safe-state controls, and muxes the wrapper serial output.
- Sits between the wrapper serial port (WSP) control signals and the WBY/WBR data registers. Replaces the fixed-width WIR plus its separate control circuitry.

Parameters:
IR_WIDTH, 4, instruction length in bits; minimum 3.
OPC_BYPASS, 0, WS_BYPASS opcode; also the value loaded at reset and on any rejected update.
OPC_EXTEST, 1, WS_EXTEST opcode.
OPC_INTEST, 2, WS_INTEST opcode.
OPC_PRELOAD, 3, WS_PRELOAD opcode.
OPC_SAFE, 4, WS_SAFE opcode.

Ports:
WRCK  in  1  wrapper clock; all state updates on its rising edge.
WRST  in  1  reset, synchronous, active-high.
SelectWIR  in  1  1 = WIR is the addressed register; 0 = the instruction-selected data register is addressed.
ShiftWR  in  1  shift enable.
CaptureWR  in  1  capture enable.
UpdateWR  in  1  update enable.
wsi  in  1  wrapper serial input.
wby_so  in  1  WBY serial output.
wbr_so  in  1  WBR serial output.
wso  out  1  wrapper serial output.
instr  out  IR_WIDTH  active (update-stage) instruction.
wby_shift, wby_capture  out  1 each  WBY controls.
wbr_shift, wbr_capture, wbr_update  out  1 each  WBR controls.
extest, intest, safe  out  1 each  decoded mode flags.
hold_inputs, hold_outputs, bus_disable  out  1 each  safe-state controls.
illegal_err  out  1  sticky flag: an update was rejected.

Behaviour:
- All state is updated on the rising edge of WRCK. WRST is synchronous, active-high and has priority over every other input.
- Reset:
  - Shift register sr = OPC_BYPASS.
  - Update register upd = OPC_BYPASS.
  - Shift counter cnt = 0.
  - illegal_err = 0.
  - All decoded outputs therefore reflect BYPASS.
- WIR operations apply only when SelectWIR=1. Exclusive priority: CaptureWR > ShiftWR > UpdateWR.
- Capture: sr <= {upd[IR_WIDTH-1:2], 2'b01}; cnt <= 0.
- Shift: sr <= {wsi, sr[IR_WIDTH-1:1]} (LSB out first); cnt <= cnt+1, saturating at IR_WIDTH. cnt is clog2(IR_WIDTH+1) bits wide.
- Update:
  - Accept when sr matches one of the five opcodes AND cnt==IR_WIDTH: upd <= sr.
  - Reject otherwise (unknown opcode or short shift): upd <= OPC_BYPASS; illegal_err <= 1.
  - In both cases cnt <= 0.
  - illegal_err clears only on reset.
- Over-shift (more than IR_WIDTH shifts): cnt stays at IR_WIDTH; the last IR_WIDTH bits shifted in are used.
- With SelectWIR=0: sr, upd and cnt hold.
- Decode is combinational from upd, so new instruction flags are visible the cycle after the update edge.
  - extest = (upd==OPC_EXTEST).
  - intest = (upd==OPC_INTEST).
  - safe = (upd==OPC_SAFE).
  - hold_inputs = hold_outputs = bus_disable = safe.
- Data register control gating (all require SelectWIR=0):
  - wby_shift = ShiftWR & bypass-or-safe; wby_capture = CaptureWR & bypass-or-safe.
  - wbr_shift = ShiftWR & (EXTEST|INTEST|PRELOAD).
  - wbr_capture = CaptureWR & (EXTEST|INTEST). PRELOAD does not capture.
  - wbr_update = UpdateWR & (EXTEST|INTEST|PRELOAD).
  - All five controls are 0 when SelectWIR=1.
- wso (combinational):
  - SelectWIR=1: sr[0].
  - SelectWIR=0 and WBR instruction active: wbr_so.
  - Otherwise: wby_so.
- Reset mid-shift or mid-update: the reset wins; the partial shift is discarded; upd returns to BYPASS.

Test Plan:
- Reset: assert WRST 1 cycle -> instr=0, wby_shift follows ShiftWR when SelectWIR=0, illegal_err=0, safe=0.
- Legal load, IR_WIDTH=4: capture, shift 4'b0001 (LSB first), update -> instr=1, extest=1; the next capture loads sr=4'b0001 (upd[3:2]=2'b00, low bits 2'b01).
- Short shift: capture, shift 3 bits of 4'b0010, update -> instr=0 (BYPASS), illegal_err=1 and stays 1 through a subsequent legal update.
- Illegal opcode: shift 4 bits of 4'b1111, update -> instr=0, illegal_err=1; wso during DR shift equals wby_so.
- SAFE: load 4'b0100 -> safe=hold_inputs=hold_outputs=bus_disable=1, wbr_* =0; a DR shift drives wby_shift=1.
- PRELOAD: load 3, then CaptureWR with SelectWIR=0 -> wbr_capture=0; ShiftWR -> wbr_shift=1 and wso=wbr_so. Assert WRST mid DR-shift -> instr=0 on the next cycle.
